// File: rtl/cal_core_sched_if.sv
// Handshake and memory-port bundle between the row scheduler and its
// environment: H/alpha read ports, core streams and the beta result port.
interface cal_core_sched_if #(
    parameter int J = 14,
    parameter int I = 7,
    parameter int A = 2
);
    localparam int IW = $clog2(I) + 1;
    localparam int AW = $clog2(I * A) + 1;

    logic              start;
    logic              busy;
    logic              done;
    logic              err_timeout;

    logic              h_rd_en;
    logic [IW-1:0]     h_rd_addr;
    logic [J-1:0]      h_rd_data;

    logic              al_rd_en;
    logic [AW-1:0]     al_rd_addr;
    logic [J*64-1:0]   al_rd_data;

    logic [J-1:0]      core_H_row;
    logic              core_H_row_tvalid;
    logic [J*64-1:0]   core_alpha_u_col;
    logic              core_alpha_u_col_tvalid;
    logic              core_alpha_u_col_tlast;

    logic [A*64-1:0]   core_beta;
    logic              core_beta_tvalid;

    logic [A*64-1:0]   beta_out;
    logic [IW-1:0]     beta_out_idx;
    logic              beta_out_valid;
    logic              beta_out_ready;

    modport slave (
        input  start, h_rd_data, al_rd_data,
        input  core_beta, core_beta_tvalid, beta_out_ready,
        output busy, done, err_timeout,
        output h_rd_en, h_rd_addr, al_rd_en, al_rd_addr,
        output core_H_row, core_H_row_tvalid,
        output core_alpha_u_col, core_alpha_u_col_tvalid,
        output core_alpha_u_col_tlast,
        output beta_out, beta_out_idx, beta_out_valid
    );

    modport master (
        output start, h_rd_data, al_rd_data,
        output core_beta, core_beta_tvalid, beta_out_ready,
        input  busy, done, err_timeout,
        input  h_rd_en, h_rd_addr, al_rd_en, al_rd_addr,
        input  core_H_row, core_H_row_tvalid,
        input  core_alpha_u_col, core_alpha_u_col_tvalid,
        input  core_alpha_u_col_tlast,
        input  beta_out, beta_out_idx, beta_out_valid
    );
endinterface

// File: rtl/cal_core_sched.sv
// Row scheduler: streams each H row and its alpha columns to the core,
// waits for the beta reply (with timeout) and hands it out per row.
module cal_core_sched #(
    parameter int J       = 14,
    parameter int I       = 7,
    parameter int A       = 2,
    parameter int TIMEOUT = 4096
) (
    input logic             clk,
    input logic             rst,
    cal_core_sched_if.slave bus
);
    localparam int IW = $clog2(I) + 1;
    localparam int AW = $clog2(I * A) + 1;
    localparam int KW = $clog2(A) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_H,
        S_SEND_H,
        S_SEND_ALPHA,
        S_WAIT_BETA,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [KW-1:0]     k_q, k_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              err_q, err_d;
    logic [A*64-1:0]   bout_q, bout_d;
    logic [IW-1:0]     bidx_q, bidx_d;
    logic              bvld_q, bvld_d;

    logic              h_en;
    logic [IW-1:0]     h_addr;
    logic              al_en;
    logic [AW-1:0]     al_addr;
    logic              h_tv;
    logic              a_tv;
    logic              a_last;
    logic              done_p;

    // State, counters and the result holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            k_q     <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            bout_q  <= '0;
            bidx_q  <= '0;
            bvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            bout_q  <= bout_d;
            bidx_q  <= bidx_d;
            bvld_q  <= bvld_d;
        end
    end

    // Next-state and per-state strobes; reads are issued one cycle ahead
    // of the beat that presents their data.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        k_d     = k_q;
        tcnt_d  = tcnt_q;
        err_d   = err_q;
        bout_d  = bout_q;
        bidx_d  = bidx_q;
        bvld_d  = bvld_q;
        h_en    = 1'b0;
        h_addr  = '0;
        al_en   = 1'b0;
        al_addr = '0;
        h_tv    = 1'b0;
        a_tv    = 1'b0;
        a_last  = 1'b0;
        done_p  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    i_d     = '0;
                    k_d     = '0;
                    tcnt_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_RD_H;
                end
            end
            S_RD_H: begin
                h_en    = 1'b1;
                h_addr  = i_q;
                state_d = S_SEND_H;
            end
            S_SEND_H: begin
                h_tv    = 1'b1;
                al_en   = 1'b1;
                al_addr = AW'(int'(i_q) * A);
                k_d     = '0;
                state_d = S_SEND_ALPHA;
            end
            S_SEND_ALPHA: begin
                a_tv = 1'b1;
                if (k_q == KW'(A - 1)) begin
                    a_last  = 1'b1;
                    tcnt_d  = '0;
                    state_d = S_WAIT_BETA;
                end else begin
                    al_en   = 1'b1;
                    al_addr = AW'(int'(i_q) * A + int'(k_q) + 1);
                    k_d     = k_q + 1'b1;
                end
            end
            S_WAIT_BETA: begin
                if (bus.core_beta_tvalid) begin
                    bout_d  = bus.core_beta;
                    bidx_d  = i_q;
                    bvld_d  = 1'b1;
                    state_d = S_OUT;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (bus.beta_out_ready) begin
                    bvld_d = 1'b0;
                    if (i_q == IW'(I - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = S_RD_H;
                    end
                end
            end
            S_DONE: begin
                done_p  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_p;
    assign bus.err_timeout = err_q;

    assign bus.h_rd_en    = h_en;
    assign bus.h_rd_addr  = h_addr;
    assign bus.al_rd_en   = al_en;
    assign bus.al_rd_addr = al_addr;

    assign bus.core_H_row              = h_tv ? bus.h_rd_data : '0;
    assign bus.core_H_row_tvalid       = h_tv;
    assign bus.core_alpha_u_col        = a_tv ? bus.al_rd_data : '0;
    assign bus.core_alpha_u_col_tvalid = a_tv;
    assign bus.core_alpha_u_col_tlast  = a_last;

    assign bus.beta_out       = bout_q;
    assign bus.beta_out_idx   = bidx_q;
    assign bus.beta_out_valid = bvld_q;
endmodule

// File: tb/tb_cal_core_sched.sv
// Randomized bench for cal_core_sched: memories, core responder and
// result sink are modelled here and checked against per-row expectations.
module tb_cal_core_sched;
    localparam int J  = 14;
    localparam int I  = 7;
    localparam int A  = 2;
    localparam int TO = 64;
    localparam int BW = A * 64;
    localparam int IW = $clog2(I) + 1;
    localparam int AW = $clog2(I * A) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cal_core_sched_if #(.J(J), .I(I), .A(A)) bus ();

    cal_core_sched #(
        .J(J), .I(I), .A(A), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [J-1:0]    mem_h  [2**IW];
    logic [J*64-1:0] mem_al [2**AW];

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.h_rd_en) bus.h_rd_data <= mem_h[bus.h_rd_addr];
        if (bus.al_rd_en) bus.al_rd_data <= mem_al[bus.al_rd_addr];
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    int cyc = 0;
    int start_cyc, exp_row, cur_row, exp_col, al_issue;
    int n_h, n_out, n_done, tlast_cyc, beta_due, beta_cyc;
    bit aborted, first_h, first_a, held = 1'b0, err_prev;
    logic [BW-1:0] sent_beta [I];
    logic [BW-1:0] hold_b;
    logic [IW-1:0] hold_i;

    int delay [I];
    int stall_row = -1, stall_len = 0, stall_cnt, rst_row = -1;
    bit rand_rdy = 1'b0, spurious = 1'b0, rst_fired;

    function automatic logic [BW-1:0] rnd_beta();
        logic [BW-1:0] r;
        for (int w = 0; w < BW / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic monitor();
        logic rdy;
        int   idx;
        if (rst) begin
            check("rst_ctl", {bus.busy, bus.done, bus.err_timeout,
                  bus.h_rd_en, bus.al_rd_en, bus.core_H_row_tvalid,
                  bus.core_alpha_u_col_tvalid, bus.core_alpha_u_col_tlast,
                  bus.beta_out_valid}, '0);
            check("rst_addr", {bus.h_rd_addr, bus.al_rd_addr}, '0);
            check("rst_data", {|bus.core_H_row, |bus.core_alpha_u_col,
                  |bus.beta_out, |bus.beta_out_idx}, '0);
            rst = 1'b0;
            aborted = 1'b1;
        end
        if (held) check("b_hold", bus.beta_out_valid, 1);
        check("core_zero",
              {!bus.core_H_row_tvalid && (|bus.core_H_row),
               !bus.core_alpha_u_col_tvalid &&
               (|bus.core_alpha_u_col || bus.core_alpha_u_col_tlast)}, '0);
        if (bus.h_rd_en) check("h_addr", bus.h_rd_addr, exp_row);
        if (bus.beta_out_valid) check("h_rd_in_out", bus.h_rd_en, 0);
        if (bus.core_H_row_tvalid) begin
            if (first_h) check("lat_h", cyc - start_cyc, 2);
            first_h = 1'b0;
            check("h_row", bus.core_H_row, mem_h[exp_row % I]);
            cur_row  = exp_row % I;
            exp_col  = 0;
            al_issue = cur_row * A;
            n_h++;
        end
        if (bus.al_rd_en) begin
            check("al_addr", bus.al_rd_addr, al_issue);
            al_issue++;
        end
        if (bus.core_alpha_u_col_tvalid) begin
            if (first_a) check("lat_a", cyc - start_cyc, 3);
            first_a = 1'b0;
            idx = cur_row * A + exp_col;
            for (int l = 0; l < J; l++)
                check("alpha", bus.core_alpha_u_col[l*64 +: 64],
                      mem_al[idx][l*64 +: 64]);
            check("tlast", bus.core_alpha_u_col_tlast, exp_col == A - 1);
            if (bus.core_alpha_u_col_tlast) begin
                tlast_cyc = cyc;
                check("al_reads", al_issue - cur_row * A, A);
            end
            exp_col++;
        end
        if (bus.beta_out_valid) begin
            if (!held) begin
                check("b_lat", cyc - beta_cyc, 1);
            end else begin
                check("b_stable", bus.beta_out, hold_b);
                check("b_idx_stable", bus.beta_out_idx, hold_i);
            end
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (exp_row == stall_row && stall_cnt < stall_len) begin
                rdy = 1'b0;
                stall_cnt++;
            end
            bus.beta_out_ready = rdy;
            if (rdy) begin
                check("b_data", bus.beta_out, sent_beta[exp_row % I]);
                check("b_idx", bus.beta_out_idx, exp_row);
                exp_row++;
                n_out++;
                held = 1'b0;
            end else begin
                held   = 1'b1;
                hold_b = bus.beta_out;
                hold_i = bus.beta_out_idx;
            end
        end else begin
            bus.beta_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 1'b0;
        end
        if (bus.done) begin
            n_done++;
            check("done_busy", bus.busy, 1);
        end
        if (bus.err_timeout && !err_prev) begin
            check("to_lat", cyc - tlast_cyc, TO + 1);
            check("to_done", bus.done, 1);
        end
        err_prev = bus.err_timeout;
    endtask

    task automatic respond();
        bus.start = 1'b0;
        bus.core_beta_tvalid = 1'b0;
        bus.core_beta = rnd_beta();
        if (spurious && bus.core_alpha_u_col_tvalid) bus.core_beta_tvalid = 1'b1;
        if (spurious && bus.core_H_row_tvalid) bus.start = 1'b1;
        if (bus.core_alpha_u_col_tlast)
            beta_due = (delay[cur_row] < 0) ? -1 : cyc + delay[cur_row];
        if (beta_due >= 0 && cyc == beta_due) begin
            sent_beta[cur_row] = bus.core_beta;
            bus.core_beta_tvalid = 1'b1;
            beta_cyc = cyc;
            beta_due = -1;
        end
        if (rst_row == cur_row && bus.core_alpha_u_col_tvalid &&
            !bus.core_alpha_u_col_tlast && !rst_fired) begin
            rst = 1'b1;
            rst_fired = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
        respond();
    endtask

    task automatic run_frame(input int exp_out, input bit exp_err,
                             input bit exp_abort);
        int n;
        int exp_h;
        for (int r = 0; r < I; r++) mem_h[r] = J'($urandom);
        for (int c = 0; c < I * A; c++)
            for (int l = 0; l < J; l++)
                mem_al[c][l*64 +: 64] = {$urandom, $urandom};
        exp_row = 0; cur_row = 0; exp_col = 0; al_issue = 0;
        n_h = 0; n_out = 0; n_done = 0;
        aborted = 1'b0; first_h = 1'b1; first_a = 1'b1; held = 1'b0;
        beta_due = -1; beta_cyc = 0; tlast_cyc = 0;
        stall_cnt = 0; rst_fired = 1'b0;
        err_prev = bus.err_timeout;
        exp_h = (exp_err || exp_abort) ? exp_out + 1 : exp_out;
        bus.start = 1'b1;
        start_cyc = cyc;
        step();
        check("busy_on", bus.busy, 1);
        check("err_clr", bus.err_timeout, 0);
        n = 0;
        while (!aborted && n_done == 0 && n < 5000) begin
            step();
            n++;
        end
        check("frame_end", n_done + int'(aborted), 1);
        check("done_cnt", n_done, exp_abort ? 0 : 1);
        check("rows_out", n_out, exp_out);
        check("h_pulses", n_h, exp_h);
        check("err_end", bus.err_timeout, exp_err);
        for (int c = 0; c < 4; c++) step();
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        check("err_hold", bus.err_timeout, exp_err);
        check("h_after", n_h, exp_h);
    endtask

    initial begin
        int to_row;
        bus.start = 1'b0;
        bus.core_beta = '0;
        bus.core_beta_tvalid = 1'b0;
        bus.beta_out_ready = 1'b1;
        for (int r = 0; r < I; r++) delay[r] = 10;
        rst = 1'b1;
        step();
        step();

        run_frame(I, 1'b0, 1'b0);

        stall_row = 3; stall_len = 5;
        run_frame(I, 1'b0, 1'b0);
        stall_row = -1;

        delay[2] = -1;
        run_frame(2, 1'b1, 1'b0);
        delay[2] = 10;

        delay[5] = TO + 1;
        run_frame(5, 1'b1, 1'b0);
        delay[5] = 10;

        delay[1] = TO; delay[4] = TO - 1;
        run_frame(I, 1'b0, 1'b0);
        delay[1] = 10; delay[4] = 10;

        spurious = 1'b1;
        run_frame(I, 1'b0, 1'b0);
        spurious = 1'b0;

        rst_row = 4;
        run_frame(4, 1'b0, 1'b1);
        rst_row = -1;
        run_frame(I, 1'b0, 1'b0);

        rand_rdy = 1'b1;
        repeat (20) begin
            to_row = -1;
            for (int r = 0; r < I; r++) begin
                delay[r] = ($urandom_range(0, 9) == 0) ?
                           $urandom_range(TO - 4, TO + 6) :
                           $urandom_range(1, 20);
                if (to_row < 0 && delay[r] > TO) to_row = r;
            end
            spurious = 1'($urandom_range(0, 1));
            run_frame(to_row < 0 ? I : to_row, to_row >= 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
